// File: rtl/shortint_bit_serializer.sv
// shortint_bit_serializer
// Takes 16-bit shortint words over a valid/ready handshake and sends them
// out one bit per cycle. Each frame is the data bits followed by an optional
// even-parity bit. The downstream sink can stall the stream with ser_ready.
module shortint_bit_serializer #(
   parameter int WORD_W    = 16,   // in_word is a shortint, so this must stay 16
   parameter bit MSB_FIRST = 1'b1, // 1: bit 15 goes out first, 0: bit 0 goes out first
   parameter bit PARITY_EN = 1'b1  // 1: append one even-parity bit to each frame
) (
   input  logic       clk,
   input  logic       rst_n,
   input  shortint    in_word,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       ser_data,
   output logic       ser_valid,
   output logic       ser_first,
   output logic       ser_last,
   input  logic       ser_ready,
   output logic       busy,
   output logic [7:0] frame_cnt
);

   localparam int               IDX_W    = $clog2(WORD_W);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DATA   = 2'd1,
      S_PARITY = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [WORD_W-1:0] shift_q, shift_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              par_q, par_d;
   logic [7:0]        frame_cnt_q, frame_cnt_d;
   // Set on the first edge after reset is released. It keeps in_ready low
   // while reset is held and for the gap before that first edge.
   logic              live_q, live_d;

   logic              out_bit;
   logic [WORD_W-1:0] shift_next;
   logic              in_fire;
   logic              ser_fire;

   // Data bit at the output end of the shift register, and the register after one shift.
   always_comb begin
      if (MSB_FIRST) begin
         out_bit    = shift_q[WORD_W-1];
         shift_next = {shift_q[WORD_W-2:0], 1'b0};
      end else begin
         out_bit    = shift_q[0];
         shift_next = {1'b0, shift_q[WORD_W-1:1]};
      end
   end

   // Output decode from the current state. All outputs are zero while idle or in reset.
   always_comb begin
      // NOTE: every output gets a default before the case statement. No path
      // through the block can then leave one unassigned and infer a latch.
      in_ready  = 1'b0;
      ser_valid = 1'b0;
      ser_data  = 1'b0;
      ser_first = 1'b0;
      ser_last  = 1'b0;
      busy      = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            in_ready = live_q;
         end
         S_DATA: begin
            ser_valid = 1'b1;
            ser_data  = out_bit;
            ser_first = (idx_q == '0);
            ser_last  = !PARITY_EN && (idx_q == LAST_IDX);
            busy      = 1'b1;
         end
         S_PARITY: begin
            ser_valid = 1'b1;
            ser_data  = par_q;
            ser_last  = 1'b1;
            busy      = 1'b1;
         end
         default: begin
            in_ready = 1'b0;
         end
      endcase
   end

   assign in_fire   = in_valid & in_ready;
   assign ser_fire  = ser_valid & ser_ready;
   assign frame_cnt = frame_cnt_q;

   // Next-state logic: accept a word, step through the data bits, then the parity bit.
   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      idx_d       = idx_q;
      par_d       = par_q;
      frame_cnt_d = frame_cnt_q;
      live_d      = 1'b1;
      unique case (state_q)
         S_IDLE: begin
            if (in_fire) begin
               // The word is sent as raw two's complement bits. Its sign has no effect.
               shift_d = WORD_W'(in_word);
               idx_d   = '0;
               par_d   = 1'b0;
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (ser_fire) begin
               // XOR of all data bits makes the 17-bit frame hold an even number of ones.
               par_d   = par_q ^ out_bit;
               shift_d = shift_next;
               idx_d   = idx_q + 1'b1;
               if (idx_q == LAST_IDX) begin
                  if (PARITY_EN) begin
                     state_d = S_PARITY;
                  end else begin
                     state_d     = S_IDLE;
                     frame_cnt_d = frame_cnt_q + 8'd1;
                  end
               end
            end
         end
         S_PARITY: begin
            if (ser_fire) begin
               state_d     = S_IDLE;
               frame_cnt_d = frame_cnt_q + 8'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State registers. Asserting reset aborts any frame in progress and clears the frame count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         // NOTE: the shift register has an explicit reset, unlike a plain
         // datapath register. The serial output can then never show X.
         shift_q     <= '0;
         idx_q       <= '0;
         par_q       <= 1'b0;
         frame_cnt_q <= 8'd0;
         live_q      <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments make every flop sample the values
         // from before the edge, regardless of statement order.
         state_q     <= state_d;
         shift_q     <= shift_d;
         idx_q       <= idx_d;
         par_q       <= par_d;
         frame_cnt_q <= frame_cnt_d;
         live_q      <= live_d;
      end
   end

endmodule

// File: doc/shortint_bit_serializer.md
Name: shortint_bit_serializer

Overview:
- Transmit-side counterpart to the 1-bit-to-shortint width-expansion path. Accepts 16-bit signed 2-state words (shortint) through a valid/ready handshake and shifts them out one bit per cycle as framed serial data.
- An optional even-parity bit is appended to each frame.
- Sits between a word-producing stage and a 1-bit logic sink. The sink can apply backpressure.

Parameters:
WORD_W, 16, data bits per frame; input port is shortint, so only 16 is legal
MSB_FIRST, 1, 1 = bit 15 sent first; 0 = bit 0 sent first
PARITY_EN, 1, 1 = append one even-parity bit after the data bits

Ports:
clk  input  1  single clock; all state updates on posedge
rst_n  input  1  asynchronous, active-low reset
in_word  input  shortint (16, signed, 2-state)  word to transmit
in_valid  input  1  in_word is valid
in_ready  output  1  block can accept a word this cycle
ser_data  output  1  serial bit (4-state logic)
ser_valid  output  1  ser_data holds a frame bit
ser_first  output  1  ser_data is the first bit of the frame
ser_last  output  1  ser_data is the last bit of the frame (parity bit if PARITY_EN, else final data bit)
ser_ready  input  1  sink consumes the current bit at this edge
busy  output  1  frame in progress (state != IDLE)
frame_cnt  output  8  count of completed frames, wraps modulo 256

Behaviour:
Reset:
- Asynchronous assertion (rst_n low) drives immediately: state=IDLE, shift register=0, bit index=0, parity accumulator=0, frame_cnt=0.
- Output values under reset: ser_data=0, ser_valid=0, ser_first=0, ser_last=0, busy=0, in_ready=0.
- in_ready goes to 1 on the first clock edge after rst_n deasserts. Deassertion is not synchronised inside the block.

FSM (states IDLE, DATA, PARITY):
- IDLE:
  - in_ready=1, ser_valid=0.
  - On edge with in_valid=1: latch in_word into the shift register, bit index=0, parity accumulator=0, go to DATA.
- DATA:
  - in_ready=0, ser_valid=1.
  - ser_data = shift register bit 15 (MSB_FIRST=1) or bit 0 (MSB_FIRST=0).
  - ser_first=1 when bit index==0.
  - On edge with ser_ready=1: accumulator ^= ser_data, shift register shifts toward the output end with 0 fill, bit index++.
  - On the transfer of bit index 15: go to PARITY if PARITY_EN, else go to IDLE and increment frame_cnt.
  - ser_last=1 during bit index 15 only when PARITY_EN=0.
- PARITY:
  - ser_valid=1, ser_data=accumulator (even parity: total count of 1s over 17 bits is even), ser_last=1, ser_first=0.
  - On edge with ser_ready=1: go to IDLE, frame_cnt++.

Handshake rules:
- Input transfer occurs when in_valid & in_ready at a posedge.
- Serial transfer occurs when ser_valid & ser_ready at a posedge.
- With ser_ready=0, ser_data, ser_first, ser_last and all state hold.
- No bit is skipped or repeated.

Latency and throughput:
- Word accepted at edge k; its first bit is presented from edge k through edge k+1.
- Minimum frame length is 16 cycles (17 with parity), plus 1 IDLE cycle between frames. Back-to-back throughput is 1 word per 18 cycles with PARITY_EN=1.

Boundary conditions:
- in_valid while busy is ignored: in_ready=0, so no transfer occurs. The upstream stage must hold in_word.
- frame_cnt at 255 plus a frame completion gives 0.
- Reset mid-frame aborts the frame. No ser_last is emitted and frame_cnt clears.
- Sign is irrelevant to serialisation; in_word bits are sent as raw two's complement.
- ser_data is never X/Z after the first reset.

Test Plan:
- MSB_FIRST=1, PARITY_EN=1, ser_ready=1, send 16'sh8001 -> ser_data 1,0x14,1, then parity 0. ser_first on bit 1 only, ser_last on bit 17 only, frame_cnt=1.
- Send -16'sd1 (0xFFFF) then 16'sh0007 back-to-back -> first frame: 16 ones, parity 0. Second frame: 13 zeros, 3 ones, parity 1. Exactly one IDLE cycle between frames (in_ready pulses once).
- MSB_FIRST=0, send 16'sh0002 -> ser_data 0,1, then 14 zeros, then parity 1.
- During frame 16'shA5A5, drive ser_ready low for 3 cycles at bit 4 -> ser_data/ser_first/ser_last stable for those cycles. Complete sequence 1010 0101 1010 0101, parity 0. in_valid pulses during busy are ignored.
- Assert rst_n low at bit 9 of a frame -> outputs 0 immediately, frame_cnt=0, no ser_last. After release, next word 16'sh0001 serialises correctly from its first bit.
- Send 256 frames -> frame_cnt reads 255 after frame 255, then wraps to 0 after frame 256.
